pc_gen: RTL

Parametrised program-counter unit; successor to the plain enable-gated PC register at the head of the fetch stage. Holds the fetch PC and selects the next PC by fixed priority among reset, exception entry, exception return, control-flow redirect and sequential increment. Buffers a redirect that arrives while fetch is stalled and applies it when the stall releases. Detects misaligned redirect targets and vectors to the exception handler, reporting the faulting address.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_gen_if.sv | 26 ++
 rtl/pc_align_chk.sv | 13 +
 rtl/pc_gen.sv | 109 ++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared PC/exception constants, FSM encoding and alignment helper.
package pc_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_INSTR_BYTES = 4;

  // Default vectors, also used by the exception/CP0 block.
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

  // Redirect-buffer FSM encoding.
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  // Low-bit mask that must be zero for an aligned address (instr_bytes is a power of two).
  function automatic int unsigned align_mask(input int unsigned instr_bytes);
    return instr_bytes - 1;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control <-> PC unit bundle: requests in, PC and fault status out.
interface pc_gen_if import pc_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              stall;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc_in;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              pend_valid;
  logic              misalign;
  logic [ADDR_W-1:0] bad_addr;

  modport master (
    output stall, redir_valid, redir_target, exc_req, eret_req, epc_in,
    input  pc, pc_plus, pend_valid, misalign, bad_addr
  );

  modport slave (
    input  stall, redir_valid, redir_target, exc_req, eret_req, epc_in,
    output pc, pc_plus, pend_valid, misalign, bad_addr
  );
endinterface

// File: rtl/pc_align_chk.sv
// Combinational alignment checker for an instruction/data address.
module pc_align_chk import pc_pkg::*; #(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              misaligned_c
);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(align_mask(INSTR_BYTES));

  // Any set bit below the alignment boundary is a fault.
  assign misaligned_c = |(addr & MASK);
endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: prioritised next-PC select with stalled-redirect buffer
// and misaligned-target trap.
module pc_gen import pc_pkg::*; #(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC     = ADDR_W'(DEF_EXC_VEC),
  parameter int unsigned       INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] pc_plus_c;
  logic [ADDR_W-1:0] tgt_c;
  logic              tgt_apply_c;
  logic              tgt_misaligned_c;

  assign pc_plus_c = pc_q + ADDR_W'(INSTR_BYTES);

  // Pick the target (eret, live redirect or buffered redirect) that is applied this edge.
  always_comb begin
    tgt_c       = bus.redir_target;
    tgt_apply_c = 1'b0;
    if (bus.exc_req) begin
      tgt_apply_c = 1'b0;
    end else if (bus.eret_req) begin
      tgt_c       = bus.epc_in;
      tgt_apply_c = 1'b1;
    end else if (bus.redir_valid) begin
      tgt_apply_c = !bus.stall;
    end else if (!bus.stall && state_q == PEND) begin
      tgt_c       = pend_tgt_q;
      tgt_apply_c = 1'b1;
    end
  end

  pc_align_chk #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_align_chk (
    .addr         (tgt_c),
    .misaligned_c (tgt_misaligned_c)
  );

  // Next state / next PC by priority: exc > eret > redirect > pending > sequential.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    bad_d      = bad_q;
    mis_d      = 1'b0;
    if (bus.exc_req) begin
      pc_d    = EXC_VEC;
      state_d = RUN;
    end else if (bus.eret_req) begin
      state_d = RUN;
    end else if (bus.redir_valid) begin
      if (bus.stall) begin
        pend_tgt_d = bus.redir_target;
        state_d    = PEND;
      end else begin
        state_d = RUN;
      end
    end else if (!bus.stall) begin
      if (state_q == PEND) begin
        state_d = RUN;
      end else begin
        pc_d = pc_plus_c;
      end
    end
    if (tgt_apply_c) begin
      if (tgt_misaligned_c) begin
        pc_d  = EXC_VEC;
        bad_d = tgt_c;
        mis_d = 1'b1;
      end else begin
        pc_d = tgt_c;
      end
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_VEC;
      pend_tgt_q <= '0;
      bad_q      <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      bad_q      <= bad_d;
      mis_q      <= mis_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus    = pc_plus_c;
  assign bus.pend_valid = (state_q == PEND);
  assign bus.misalign   = mis_q;
  assign bus.bad_addr   = bad_q;
endmodule
